// File: rtl/sdp_y_core_chn_mul_in_rsci_if.sv
// Stream bundle between the upstream producer, the SDP Y-core pipeline and the
// chn_mul_in receive interface. The receiver uses the slave modport.
interface sdp_y_core_chn_mul_in_rsci_if #(
    parameter int WIDTH = 128,
    parameter int CNT_W = 16
);
    logic [WIDTH-1:0] chn_mul_in_rsc_z;
    logic             chn_mul_in_rsc_vz;
    logic             chn_mul_in_rsc_lz;
    logic             chn_mul_in_rsci_oswt;
    logic             core_wen;
    logic             chn_mul_in_rsci_bawt;
    logic             chn_mul_in_rsci_wen_comp;
    logic [WIDTH-1:0] chn_mul_in_rsci_d_mxwt;
    logic [CNT_W-1:0] chn_mul_in_rsci_stall_cnt;

    modport master (
        output chn_mul_in_rsc_z,
        output chn_mul_in_rsc_vz,
        output chn_mul_in_rsci_oswt,
        output core_wen,
        input  chn_mul_in_rsc_lz,
        input  chn_mul_in_rsci_bawt,
        input  chn_mul_in_rsci_wen_comp,
        input  chn_mul_in_rsci_d_mxwt,
        input  chn_mul_in_rsci_stall_cnt
    );

    modport slave (
        input  chn_mul_in_rsc_z,
        input  chn_mul_in_rsc_vz,
        input  chn_mul_in_rsci_oswt,
        input  core_wen,
        output chn_mul_in_rsc_lz,
        output chn_mul_in_rsci_bawt,
        output chn_mul_in_rsci_wen_comp,
        output chn_mul_in_rsci_d_mxwt,
        output chn_mul_in_rsci_stall_cnt
    );
endinterface

// File: rtl/sdp_y_core_chn_mul_in_rsci.sv
// Receive-side channel interface for SDP Y-core: 2-entry skid FIFO plus starvation counter.
// Optional feature macro SDP_Y_CORE_CHN_IN_BYPASS_EN enables a zero-latency bypass when the FIFO is empty.
module sdp_y_core_chn_mul_in_rsci #(
    parameter int WIDTH = 128,
    parameter int CNT_W = 16
) (
    input  logic                            nvdla_core_clk,
    input  logic                            nvdla_core_rst,
    sdp_y_core_chn_mul_in_rsci_if.slave     chn
);

    logic [1:0]       r_cnt;
    logic             r_wrPtr;
    logic             r_rdPtr;
    logic [WIDTH-1:0] r_mem [0:1];
    logic [CNT_W-1:0] r_stallCnt;

    logic             w_lz;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_bawt;
    logic             w_passThru;
    logic             w_wrEn;
    logic             w_rdEn;
    logic [WIDTH-1:0] w_headData;

    // Ready depends only on registered occupancy and reset, never on vz.
    assign w_lz    = ~nvdla_core_rst & (r_cnt != 2'd2);
    assign w_push  = chn.chn_mul_in_rsc_vz & w_lz;
    assign w_empty = (r_cnt == 2'd0);

`ifdef SDP_Y_CORE_CHN_IN_BYPASS_EN
    assign w_bawt     = w_empty ? w_push : 1'b1;
    assign w_headData = w_empty ? chn.chn_mul_in_rsc_z : r_mem[r_rdPtr];
`else
    assign w_bawt     = ~w_empty;
    assign w_headData = r_mem[r_rdPtr];
`endif

    assign w_pop = chn.chn_mul_in_rsci_oswt & chn.core_wen & w_bawt;

    // A word handed straight through an empty FIFO never touches storage.
    assign w_passThru = w_empty & w_push & w_pop;
    assign w_wrEn     = w_push & ~w_passThru;
    assign w_rdEn     = w_pop & ~w_passThru;

    assign chn.chn_mul_in_rsc_lz         = w_lz;
    assign chn.chn_mul_in_rsci_bawt      = w_bawt;
    assign chn.chn_mul_in_rsci_wen_comp  = ~chn.chn_mul_in_rsci_oswt | w_bawt;
    assign chn.chn_mul_in_rsci_d_mxwt    = w_bawt ? w_headData : '0;
    assign chn.chn_mul_in_rsci_stall_cnt = r_stallCnt;

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_cnt   <= 2'd0;
            r_wrPtr <= 1'b0;
            r_rdPtr <= 1'b0;
        end else begin
            case ({w_wrEn, w_rdEn})
                2'b10:   r_cnt <= r_cnt + 2'd1;
                2'b01:   r_cnt <= r_cnt - 2'd1;
                default: r_cnt <= r_cnt;
            endcase
            if (w_wrEn) begin
                r_wrPtr <= ~r_wrPtr;
            end
            if (w_rdEn) begin
                r_rdPtr <= ~r_rdPtr;
            end
        end
    end

    // Storage is intentionally left unreset; the output mux hides stale entries.
    always_ff @(posedge nvdla_core_clk) begin
        if (w_wrEn) begin
            r_mem[r_wrPtr] <= chn.chn_mul_in_rsc_z;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            r_stallCnt <= '0;
        end else if (chn.chn_mul_in_rsci_oswt & chn.core_wen & ~w_bawt & ~(&r_stallCnt)) begin
            r_stallCnt <= r_stallCnt + CNT_W'(1);
        end
    end

endmodule
